// File: rtl/activation_pipeline_if.sv
// activation_pipeline_if
//   Stream bundle for activation_pipeline: input beat handshake and output
//   beat handshake. Lane k of a beat is in_data[k] / out_data[k], which is
//   bits [k*DATA_WIDTH +: DATA_WIDTH] of the flattened vector.
//   modport slave  : the pipeline (consumes in_*, produces out_*)
//   modport master : the producer/consumer around it
interface activation_pipeline_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_data;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/activation_pipeline.sv
// activation_pipeline
//   Two-stage, NUM_CHANNELS-wide activation unit (none / relu / leaky relu /
//   clamp) with valid/ready flow control on both sides.
//   S1 captures x and x*alpha plus the beat's mode and clamp bound;
//   S2 selects, shifts, saturates and holds the output.
//   Ports:
//     core_clk, resetn      clock, async active-low reset
//     sel_activation        0 none, 1 relu, 2 leaky relu, 3 clamp
//     leaky_alpha           signed slope, FRAC_WIDTH fractional bits
//     clamp_max             signed upper bound for clamp mode
//     bus (slave)           in_valid/in_ready/in_data, out_valid/out_ready/out_data
//     busy                  any stage holds a beat
//   Build option: ACTIVATION_PIPELINE_SAT_EN saturates the leaky-relu result
//   to the DATA_WIDTH signed range; otherwise it wraps to the low bits.

module activation_pipeline_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                         core_clk,
    input  logic                         resetn,
    input  logic                         s1_load,
    input  logic                         s2_load,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] alpha,
    input  logic [1:0]                   mode,   // already registered in S1
    input  logic signed [DATA_WIDTH-1:0] cmax,   // already registered in S1
    output logic [DATA_WIDTH-1:0]        y
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [PW-1:0]         prod_q;
    logic signed [PW-1:0]         shifted;
    logic signed [DATA_WIDTH-1:0] leaky;
    logic signed [DATA_WIDTH-1:0] cmax_pos;
    logic signed [DATA_WIDTH-1:0] y_d;

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            prod_q <= '0;
        end else if (s1_load) begin
            x_q    <= x_in;
            prod_q <= $signed({{DATA_WIDTH{x_in[DATA_WIDTH-1]}}, x_in})
                    * $signed({{DATA_WIDTH{alpha[DATA_WIDTH-1]}}, alpha});
        end
    end

    // Arithmetic shift: rounds toward minus infinity.
    assign shifted = prod_q >>> FRAC_WIDTH;

`ifdef ACTIVATION_PIPELINE_SAT_EN
    localparam logic signed [PW-1:0] SMAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    always_comb begin
        leaky = shifted[DATA_WIDTH-1:0];
        if (shifted > SMAX)      leaky = SMAX[DATA_WIDTH-1:0];
        else if (shifted < SMIN) leaky = SMIN[DATA_WIDTH-1:0];
    end
`else
    assign leaky = shifted[DATA_WIDTH-1:0];
`endif

    // A negative bound clamps every non-negative input to zero.
    assign cmax_pos = cmax[DATA_WIDTH-1] ? '0 : cmax;

    always_comb begin
        y_d = x_q;
        case (mode)
            2'd0:    y_d = x_q;
            2'd1:    y_d = x_q[DATA_WIDTH-1] ? '0 : x_q;
            2'd2:    y_d = x_q[DATA_WIDTH-1] ? leaky : x_q;
            default: y_d = x_q[DATA_WIDTH-1] ? '0 : ((x_q > cmax_pos) ? cmax_pos : x_q);
        endcase
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn)      y <= '0;
        else if (s2_load) y <= y_d;
    end
endmodule

module activation_pipeline #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_WIDTH   = 8
) (
    input  logic                  core_clk,
    input  logic                  resetn,
    input  logic [1:0]            sel_activation,
    input  logic [DATA_WIDTH-1:0] leaky_alpha,
    input  logic [DATA_WIDTH-1:0] clamp_max,
    activation_pipeline_if.slave  bus,
    output logic                  busy
);
    logic [2:1]                              vld_pipe;   // [1]=S1, [2]=S2
    logic                                    s2_adv;
    logic                                    accept;
    logic [1:0]                              mode_q;
    logic [DATA_WIDTH-1:0]                   cmax_q;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] x_lane;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] y_lane;

    // S2 moves when it is empty or draining; S1 can refill whenever it
    // empties in the same edge, so ready never looks at in_valid.
    assign s2_adv        = !vld_pipe[2] || bus.out_ready;
    assign bus.in_ready  = !vld_pipe[1] || s2_adv;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = vld_pipe[2];
    assign busy          = |vld_pipe;
    assign x_lane        = bus.in_data;
    assign bus.out_data  = y_lane;

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            mode_q   <= '0;
            cmax_q   <= '0;
        end else begin
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (accept) begin
                vld_pipe[1] <= 1'b1;
                mode_q      <= sel_activation;
                cmax_q      <= clamp_max;
            end else if (s2_adv) begin
                vld_pipe[1] <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        activation_pipeline_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_WIDTH(FRAC_WIDTH)
        ) u_lane (
            .core_clk(core_clk),
            .resetn  (resetn),
            .s1_load (accept),
            .s2_load (vld_pipe[1] && s2_adv),
            .x_in    (x_lane[g]),
            .alpha   (leaky_alpha),
            .mode    (mode_q),
            .cmax    (cmax_q),
            .y       (y_lane[g])
        );
    end
endmodule

// File: tb/tb_activation_pipeline.sv
module tb_activation_pipeline;
    logic        core_clk;
    logic        resetn;
    logic [1:0]  sel;
    logic [15:0] alpha;
    logic [15:0] cmax;
    logic        busy;
    int          n_vec = 0;
    int          n_err = 0;

    activation_pipeline_if #(.NUM_CHANNELS(4), .DATA_WIDTH(16)) bus ();

    activation_pipeline #(
        .NUM_CHANNELS(4),
        .DATA_WIDTH  (16),
        .FRAC_WIDTH  (8)
    ) dut (
        .core_clk      (core_clk),
        .resetn        (resetn),
        .sel_activation(sel),
        .leaky_alpha   (alpha),
        .clamp_max     (cmax),
        .bus           (bus),
        .busy          (busy)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // One beat with out_ready high: checks 2-cycle latency and the result.
    // Config inputs are scrambled after acceptance to show they travel with the beat.
    task automatic beat(input string tag, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] cm, input logic [63:0] d, input logic [63:0] exp);
        @(negedge core_clk);
        sel = m; alpha = a; cmax = cm;
        bus.in_valid = 1'b1; bus.in_data = d; bus.out_ready = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        bus.in_valid = 1'b0; bus.in_data = '0;
        sel = ~m; alpha = 16'h5A5A; cmax = 16'h0001;
        chk({tag, ".lat"}, 64'(bus.out_valid), 64'd0);
        @(posedge core_clk);
        @(negedge core_clk);
        chk({tag, ".vld"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".dat"}, bus.out_data, exp);
    endtask

    logic [63:0] bp [6];
    logic [63:0] a_dat;
    int          sent, rcvd;
    logic        fire_in, fire_out, stale;

    initial begin
        resetn = 1'b0; sel = 2'd0; alpha = '0; cmax = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.busy",      64'(busy),          64'd0);
        chk("rst.out_data",  bus.out_data,       64'd0);
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        resetn = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // Function per mode
        beat("none", 2'd0, 16'h0000, 16'h0000,
             pack4(16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF),
             pack4(16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF));
        beat("relu", 2'd1, 16'h0000, 16'h0000,
             pack4(16'hFF00, 16'h0100, 16'h0000, 16'h8000),
             pack4(16'h0000, 16'h0100, 16'h0000, 16'h0000));
        beat("leaky", 2'd2, 16'h0019, 16'h0000,
             pack4(16'hFF00, 16'h0100, 16'h0000, 16'hFFFF),
             pack4(16'hFFE7, 16'h0100, 16'h0000, 16'hFFFF));
        beat("leaky.half", 2'd2, 16'h0080, 16'h0000,
             pack4(16'hFFFD, 16'hFFFF, 16'h8000, 16'h7FFF),
             pack4(16'hFFFE, 16'hFFFF, 16'hC000, 16'h7FFF));
`ifdef ACTIVATION_PIPELINE_SAT_EN
        beat("leaky.sat", 2'd2, 16'h0200, 16'h0000,
             pack4(16'h8000, 16'hFFFF, 16'h0100, 16'h7FFF),
             pack4(16'h8000, 16'hFFFE, 16'h0100, 16'h7FFF));
`else
        beat("leaky.wrap", 2'd2, 16'h0200, 16'h0000,
             pack4(16'h8000, 16'hFFFF, 16'h0100, 16'h7FFF),
             pack4(16'h0000, 16'hFFFE, 16'h0100, 16'h7FFF));
`endif
        beat("clamp", 2'd3, 16'h0000, 16'h0600,
             pack4(16'h0800, 16'h0300, 16'hF000, 16'h0600),
             pack4(16'h0600, 16'h0300, 16'h0000, 16'h0600));
        beat("clamp.neg", 2'd3, 16'h0000, 16'hFF00,
             pack4(16'h0100, 16'h0000, 16'hFFFF, 16'h7FFF),
             pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000));

        // Backpressure: out_ready low for cycles 0..6, then released
        for (int i = 0; i < 6; i++)
            bp[i] = pack4(16'(i + 1), 16'(16'h0100 + i), 16'hF000, 16'(i * 3));
        sel = 2'd0; sent = 0; rcvd = 0;
        for (int c = 0; c < 30 && rcvd < 6; c++) begin
            @(negedge core_clk);
            bus.out_ready = (c >= 7);
            bus.in_valid  = (sent < 6);
            if (sent < 6) bus.in_data = bp[sent];
            else          bus.in_data = '0;
            #1;
            if (c >= 2 && c <= 6) begin
                chk("bp.stall_rdy", 64'(bus.in_ready), 64'd0);
                chk("bp.hold",      bus.out_data,      bp[0]);
            end
            if (c >= 7) chk("bp.thru", 64'(bus.out_valid), 64'd1);
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                chk("bp.order", bus.out_data, bp[rcvd]);
                rcvd++;
            end
            if (fire_in) sent++;
        end
        chk("bp.count", 64'(rcvd), 64'd6);
        @(negedge core_clk);
        bus.in_valid = 1'b0;
        #1;
        chk("bp.idle", 64'(busy), 64'd0);

        // Mode switched right after beat A is accepted
        a_dat = pack4(16'hFF00, 16'h0100, 16'h8000, 16'h0005);
        @(negedge core_clk);
        bus.out_ready = 1'b1; sel = 2'd1; bus.in_valid = 1'b1; bus.in_data = a_dat;
        @(posedge core_clk);
        @(negedge core_clk);
        sel = 2'd0;
        @(posedge core_clk);
        @(negedge core_clk);
        bus.in_valid = 1'b0;
        chk("sw.a", bus.out_data, pack4(16'h0000, 16'h0100, 16'h0000, 16'h0005));
        @(posedge core_clk);
        @(negedge core_clk);
        chk("sw.b_vld", 64'(bus.out_valid), 64'd1);
        chk("sw.b", bus.out_data, a_dat);

        // Reset with two beats held
        @(negedge core_clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = bp[2];
        @(posedge core_clk);
        @(negedge core_clk);
        bus.in_data = bp[3];
        @(posedge core_clk);
        @(negedge core_clk);
        bus.in_valid = 1'b0;
        #1;
        chk("mid.busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid.busy0",     64'(busy),          64'd0);
        chk("mid.out_data",  bus.out_data,       64'd0);
        @(posedge core_clk);
        @(negedge core_clk);
        resetn = 1'b1; bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge core_clk);
            stale = stale | bus.out_valid | busy;
        end
        chk("mid.stale", 64'(stale), 64'd0);
        chk("mid.in_ready", 64'(bus.in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/activation_pipeline.md
ACTIVATION_PIPELINE -- requirements
Module: activation_pipeline

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, giving the number of parallel lanes per beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, giving the signed fixed-point width of each lane.
REQ-003 SHALL have parameter FRAC_WIDTH, default 8, giving the fractional bits of leaky_alpha; legal range 0 to DATA_WIDTH-1.
REQ-004 SHALL have port core_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port sel_activation, input, 2 bits: 0 = none, 1 = relu, 2 = leaky relu, 3 = clamp.
REQ-007 SHALL have port leaky_alpha, input, DATA_WIDTH bits: signed slope with FRAC_WIDTH fractional bits.
REQ-008 SHALL have port clamp_max, input, DATA_WIDTH bits: signed upper bound for mode 3.
REQ-009 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, NUM_CHANNELS*DATA_WIDTH bits); lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_data (output, NUM_CHANNELS*DATA_WIDTH bits), with the same lane packing as in_data.
REQ-011 SHALL have port busy, output, 1 bit: high while any pipeline stage holds a beat.

Function
REQ-012 SHALL accept a beat on a rising edge where in_valid and in_ready are both high.
REQ-013 SHALL transfer a beat out on a rising edge where out_valid and out_ready are both high.
REQ-014 SHALL have two register stages: S1 (operand/product capture) and S2 (select, shift, saturate, output).
REQ-015 SHALL assert out_valid for a beat from the second rising edge after its acceptance when out_ready is held high, i.e. latency 2 cycles.
REQ-016 SHALL sustain throughput of one beat per cycle while out_ready is high.
REQ-017 SHALL advance S2 when S2 is empty or out_ready is high, and advance S1 into S2 when S1 is valid and S2 advances.
REQ-018 SHALL drive in_ready = !S1_valid || S2-advance, combinationally, with no path from in_valid.
REQ-019 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-020 SHALL lose, duplicate or reorder no beat under any out_ready pattern; at most 2 beats are stored.
REQ-021 SHALL sample sel_activation, leaky_alpha and clamp_max at beat acceptance and carry them with the beat, so mid-stream changes affect only later beats.
REQ-022 SHALL in mode 0 output x unchanged.
REQ-023 SHALL in mode 1 output 0 if x < 0, else x.
REQ-024 SHALL in mode 2 output x if x >= 0, else (x*alpha) >>> FRAC_WIDTH, using a 2*DATA_WIDTH signed product and arithmetic shift (rounds toward minus infinity).
REQ-025 SHALL in mode 3 output 0 if x < 0, otherwise min(x, max(clamp_max, 0)).
REQ-026 SHALL process all lanes independently and identically within the same cycle.
REQ-027 SHALL drive busy = S1_valid || S2_valid.

Reset
REQ-028 SHALL, while resetn is low, force S1_valid=0, S2_valid=0, out_valid=0, out_data=0, busy=0 and all sampled config registers=0, irrespective of core_clk.
REQ-029 SHALL drive in_ready high from the first rising edge after resetn deasserts.
REQ-030 SHALL discard beats in flight when reset asserts mid-stream, and SHALL emit nothing from before the reset afterwards.

Configuration
REQ-031 SHALL, when macro ACTIVATION_PIPELINE_SAT_EN is defined, saturate the mode 2 shifted result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-032 SHALL, when ACTIVATION_PIPELINE_SAT_EN is undefined, output the low DATA_WIDTH bits of the mode 2 shifted result (wrap), with no saturation logic instantiated; modes 0, 1 and 3 SHALL be unaffected either way.

Verification (DATA_WIDTH=16, FRAC_WIDTH=8, NUM_CHANNELS=4)
REQ-033 SHALL pass this case: mode 2, alpha=0x0019, lanes {0xFF00, 0x0100, 0x0000, 0xFFFF}, out_ready=1 -> two cycles later, lanes {0xFFE7, 0x0100, 0x0000, 0xFFFF}.
REQ-034 SHALL pass this case: mode 2, alpha=0x0200, lane 0x8000 -> 0x8000 with SAT_EN defined, 0x0000 without.
REQ-035 SHALL pass this case: mode 3, clamp_max=0x0600, lanes {0x0800, 0x0300, 0xF000, 0x0600} -> {0x0600, 0x0300, 0x0000, 0x0600}; and clamp_max=0xFF00 with lane 0x0100 -> 0x0000.
REQ-036 SHALL pass this case: continuous in_valid with out_ready low 5 cycles -> in_ready low after 2 beats held, out_data stable; on release, all beats in order, one per cycle.
REQ-037 SHALL pass this case: sel_activation switched 1->0 on the cycle after beat A accepted -> beat A relu'd, beat B passthrough.
REQ-038 SHALL pass this case: resetn pulsed low with 2 beats in flight -> out_valid=0 and busy=0 immediately, no stale beat emitted after release.
